// File: rtl/xor_acc_pkg.sv
// Shared definitions for the XOR frame accumulator: default sizes and
// the FSM state encoding used by xor_acc_stream.
package xor_acc_pkg;

   localparam int XOR_ACC_WIDTH_DEF     = 8;
   localparam int XOR_ACC_FRAME_LEN_DEF = 4;

   typedef logic [1:0] xor_acc_state_t;

   localparam xor_acc_state_t IDLE = 2'd0;
   localparam xor_acc_state_t ACC  = 2'd1;
   localparam xor_acc_state_t HOLD = 2'd2;

endpackage

// File: rtl/xor_reduce.sv
// Combinational reduction XOR of a WIDTH-bit word (parity of the word).
module xor_reduce #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] din,
   output logic             parity
);

   // Odd number of ones gives parity 1.
   always_comb begin
      parity = ^din;
   end

endmodule

// File: rtl/xor_acc_stream.sv
// Streaming XOR accumulator: folds FRAME_LEN input words into one result
// (XOR, parity, word count) presented with a valid/ready handshake.
// Optional build macro XOR_ACC_EARLY_LAST_EN adds an in_last input that
// can close a frame before FRAME_LEN words have arrived.
//
// state | meaning
// IDLE  | no frame in progress, acc/cnt are 0, accepting the first word
// ACC   | frame partially received, accepting further words
// HOLD  | frame complete, result presented until consumed
module xor_acc_stream
   import xor_acc_pkg::*;
#(
   parameter int  WIDTH     = XOR_ACC_WIDTH_DEF,
   parameter int  FRAME_LEN = XOR_ACC_FRAME_LEN_DEF,
   localparam int CW        = $clog2(FRAME_LEN + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
`ifdef XOR_ACC_EARLY_LAST_EN
   input  logic             in_last,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_xor,
   output logic             out_parity,
   output logic [CW-1:0]    out_count
);

   localparam logic [CW-1:0] LEN_C = CW'(FRAME_LEN);

   xor_acc_state_t   state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             last_flag;
   logic             acc_par;

`ifdef XOR_ACC_EARLY_LAST_EN
   assign last_flag = in_last;
`else
   assign last_flag = 1'b0;
`endif

   xor_reduce #(.WIDTH(WIDTH)) u_xor_reduce (
      .din    (acc_q),
      .parity (acc_par)
   );

   // Next-state, accumulator and word-count update.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE, ACC: begin
            // in_ready is 1 in both states, so in_valid alone means accept.
            // cnt never exceeds FRAME_LEN-1 here, so the increment cannot wrap.
            if (in_valid) begin
               acc_d   = (state_q == IDLE) ? in_data : (acc_q ^ in_data);
               cnt_d   = cnt_q + CW'(1);
               state_d = ((cnt_d == LEN_C) || last_flag) ? HOLD : ACC;
            end
         end
         HOLD: begin
            if (out_ready) begin
               state_d = IDLE;
               acc_d   = '0;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
      end
   end

   // Handshake and result outputs; result fields read as 0 outside HOLD.
   always_comb begin
      in_ready   = (state_q != HOLD);
      out_valid  = (state_q == HOLD);
      out_xor    = out_valid ? acc_q : '0;
      out_parity = out_valid & acc_par;
      out_count  = out_valid ? cnt_q : '0;
   end

endmodule

// File: tb/tb_xor_acc_stream.sv
// Self-checking bench for xor_acc_stream: directed frames plus random
// traffic, checked by a queue-based scoreboard against a frame-level model.
module tb_xor_acc_stream;

   localparam int W   = 8;
   localparam int FL  = 4;
   localparam int CW  = $clog2(FL + 1);
`ifdef XOR_ACC_EARLY_LAST_EN
   localparam bit EARLY = 1'b1;
`else
   localparam bit EARLY = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic [W-1:0]  in_data = '0;
   logic          in_last = 1'b0;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic [W-1:0]  out_xor;
   logic          out_parity;
   logic [CW-1:0] out_count;

   logic          v1 = 1'b0;
   logic          r1;
   logic [W-1:0]  d1 = '0;
   logic          l1 = 1'b0;
   logic          ov1;
   logic          ord1 = 1'b1;
   logic [W-1:0]  x1;
   logic          p1;
   logic [0:0]    c1;

   always #5 clk = ~clk;

   xor_acc_stream #(.WIDTH(W), .FRAME_LEN(FL)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_data    (in_data),
`ifdef XOR_ACC_EARLY_LAST_EN
      .in_last    (in_last),
`endif
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_xor    (out_xor),
      .out_parity (out_parity),
      .out_count  (out_count)
   );

   xor_acc_stream #(.WIDTH(W), .FRAME_LEN(1)) dut1 (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (v1),
      .in_ready   (r1),
      .in_data    (d1),
`ifdef XOR_ACC_EARLY_LAST_EN
      .in_last    (l1),
`endif
      .out_valid  (ov1),
      .out_ready  (ord1),
      .out_xor    (x1),
      .out_parity (p1),
      .out_count  (c1)
   );

   typedef struct {
      logic [W-1:0] x;
      int           n;
   } exp_t;

   exp_t         sb[$];
   logic [W-1:0] frame_q[$];
   exp_t         e_new;
   int           tests = 0;
   int           fails = 0;
   bit           mon_en = 1'b0;
   int           cons_cnt = 0;
   logic [W-1:0] last_x = '0;
   logic         last_p = 1'b0;
   int           last_n = 0;
   bit           rand_en = 1'b0;
   logic         out_ready_dir = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Consumer: random or directed out_ready, updated mid-cycle.
   initial begin
      forever begin
         @(posedge clk);
         #2;
         out_ready = rand_en ? 1'($urandom_range(0, 1)) : out_ready_dir;
      end
   end

   // Reference model: collects accepted words per frame and queues the
   // expected result once the frame is complete.
   always @(negedge clk) begin
      #1;
      if (!rst_n) begin
         frame_q.delete();
         sb.delete();
      end else if (in_valid && in_ready) begin
         frame_q.push_back(in_data);
         if (frame_q.size() == FL || (EARLY && in_last)) begin
            e_new.x = '0;
            foreach (frame_q[i]) e_new.x = e_new.x ^ frame_q[i];
            e_new.n = frame_q.size();
            sb.push_back(e_new);
            frame_q.delete();
         end
      end
   end

   // Monitor: a pending expected result means the DUT must be presenting it.
   always @(negedge clk) begin
      if (mon_en) begin
         chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
         if (sb.size() != 0) begin
            if (out_valid) begin
               chk("out_xor",    32'(out_xor),    32'(sb[0].x));
               chk("out_parity", 32'(out_parity), 32'($countones(sb[0].x) % 2));
               chk("out_count",  32'(out_count),  32'(sb[0].n));
               chk("in_ready_hold", 32'(in_ready), 32'(0));
               if (out_ready && rst_n) begin
                  last_x = out_xor;
                  last_p = out_parity;
                  last_n = int'(out_count);
                  void'(sb.pop_front());
                  cons_cnt++;
               end
            end
         end else if (!out_valid) begin
            chk("idle_out_xor",    32'(out_xor),    32'(0));
            chk("idle_out_parity", 32'(out_parity), 32'(0));
            chk("idle_out_count",  32'(out_count),  32'(0));
            chk("idle_in_ready",   32'(in_ready),   32'(1));
         end
      end
   end

   task automatic send(input logic [W-1:0] d, input logic last, input int gap);
      bit done = 1'b0;
      in_valid = 1'b0;
      repeat (gap) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = last;
      for (int k = 0; k < 64 && !done; k++) begin
         @(negedge clk);
         if (in_ready === 1'b1) done = 1'b1;
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      in_last  = 1'b0;
      chk("send_accepted", 32'(done), 32'(1));
   endtask

   task automatic wait_cons(input int prev);
      bit done = 1'b0;
      for (int k = 0; k < 100 && !done; k++) begin
         @(negedge clk);
         #2;
         if (cons_cnt > prev) done = 1'b1;
      end
      chk("result_consumed", 32'(done), 32'(1));
      @(posedge clk);
      #1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1;
      rst_n  = 1'b1;
      mon_en = 1'b1;

      // Reset state
      @(negedge clk);
      chk("rst_in_ready",  32'(in_ready),   32'(1));
      chk("rst_out_valid", 32'(out_valid),  32'(0));
      chk("rst_out_xor",   32'(out_xor),    32'(0));
      chk("rst_out_count", 32'(out_count),  32'(0));
      chk("rst_parity",    32'(out_parity), 32'(0));
      chk("rst1_in_ready", 32'(r1),         32'(1));
      chk("rst1_out_valid", 32'(ov1),       32'(0));
      @(posedge clk);
      #1;

      // Basic back-to-back frame
      out_ready_dir = 1'b1;
      c = cons_cnt;
      send(8'h01, 1'b0, 0);
      send(8'h02, 1'b0, 0);
      send(8'h04, 1'b0, 0);
      send(8'h08, 1'b0, 0);
      chk("basic_latency", 32'(out_valid), 32'(1));
      wait_cons(c);
      chk("basic_xor",    32'(last_x), 32'h0F);
      chk("basic_parity", 32'(last_p), 32'(0));
      chk("basic_count",  32'(last_n), 32'(4));

      // Backpressure: result held for 5 cycles
      out_ready_dir = 1'b0;
      c = cons_cnt;
      send(8'hFF, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      send(8'h00, 1'b0, 0);
      send(8'h01, 1'b0, 0);
      for (int i = 0; i < 5; i++) begin
         chk("bp_in_ready",  32'(in_ready),   32'(0));
         chk("bp_out_valid", 32'(out_valid),  32'(1));
         chk("bp_out_xor",   32'(out_xor),    32'hFE);
         chk("bp_parity",    32'(out_parity), 32'(1));
         @(posedge clk);
         #1;
      end
      out_ready_dir = 1'b1;
      wait_cons(c);
      chk("bp_xor",         32'(last_x),    32'hFE);
      chk("bp_release_rdy", 32'(in_ready),  32'(1));
      chk("bp_release_ov",  32'(out_valid), 32'(0));

      // Gaps between words
      c = cons_cnt;
      send(8'hAA, 1'b0, 0);
      send(8'h55, 1'b0, 2);
      send(8'hAA, 1'b0, 3);
      chk("gap_no_early", 32'(out_valid), 32'(0));
      send(8'h55, 1'b0, 1);
      wait_cons(c);
      chk("gap_xor",   32'(last_x), 32'h00);
      chk("gap_count", 32'(last_n), 32'(4));

      // Reset mid-frame, then a clean frame
      send(8'h11, 1'b0, 0);
      send(8'h22, 1'b0, 0);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("midrst_in_ready", 32'(in_ready),  32'(1));
      chk("midrst_out_cnt",  32'(out_count), 32'(0));
      c = cons_cnt;
      send(8'h10, 1'b0, 0);
      send(8'h20, 1'b0, 0);
      send(8'h40, 1'b0, 0);
      send(8'h80, 1'b0, 0);
      wait_cons(c);
      chk("midrst_xor",   32'(last_x), 32'hF0);
      chk("midrst_count", 32'(last_n), 32'(4));

      // Reset while holding a result discards it
      out_ready_dir = 1'b0;
      c = cons_cnt;
      for (int i = 0; i < FL; i++) send(W'($urandom), 1'b0, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      chk("holdrst_out_valid", 32'(out_valid), 32'(0));
      chk("holdrst_no_output", 32'(cons_cnt),  32'(c));
      out_ready_dir = 1'b1;

      // FRAME_LEN=1 instance
      d1 = 8'h3C;
      v1 = 1'b1;
      @(negedge clk);
      chk("fl1_in_ready", 32'(r1), 32'(1));
      @(posedge clk);
      #1;
      v1 = 1'b0;
      chk("fl1_out_valid", 32'(ov1), 32'(1));
      chk("fl1_out_xor",   32'(x1),  32'h3C);
      chk("fl1_parity",    32'(p1),  32'(0));
      chk("fl1_count",     32'(c1),  32'(1));
      @(posedge clk);
      #1;
      chk("fl1_done_valid", 32'(ov1), 32'(0));
      chk("fl1_done_ready", 32'(r1),  32'(1));
      chk("fl1_done_xor",   32'(x1),  32'(0));

`ifdef XOR_ACC_EARLY_LAST_EN
      // Early frame end
      c = cons_cnt;
      send(8'h0F, 1'b0, 0);
      send(8'hF1, 1'b1, 0);
      wait_cons(c);
      chk("early_xor",    32'(last_x), 32'hFE);
      chk("early_count",  32'(last_n), 32'(2));
      chk("early_parity", 32'(last_p), 32'(1));
`endif

      // Random traffic with random consumer backpressure
      rand_en = 1'b1;
      for (int i = 0; i < 200; i++) begin
         send(W'($urandom),
              EARLY ? ($urandom_range(0, 5) == 0) : 1'b0,
              int'($urandom_range(0, 2)));
      end
      rand_en = 1'b0;
      out_ready_dir = 1'b1;
      for (int k = 0; k < 20 && sb.size() != 0; k++) begin
         @(posedge clk);
         #1;
      end
      chk("drain_empty", 32'(sb.size()), 32'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/xor_acc_stream.md
XOR_ACC_STREAM -- requirements
Module: xor_acc_stream

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: data word width in bits, legal range 1 or more.
REQ-002 The block SHALL have parameter FRAME_LEN, default 4: words per frame, legal range 1 or more.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset that is synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: input word present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 The block SHALL have port in_data, input, WIDTH bits: input word.
REQ-008 The block SHALL have port out_valid, output, 1 bit: frame result present.
REQ-009 The block SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 The block SHALL have port out_xor, output, WIDTH bits: bitwise XOR of all words in the frame.
REQ-011 The block SHALL have port out_parity, output, 1 bit: reduction XOR of out_xor.
REQ-012 The block SHALL have port out_count, output, CW bits, where CW = $clog2(FRAME_LEN+1): number of words in the frame.

Function
REQ-013 An input word SHALL be accepted only in a cycle where in_valid and in_ready are both 1; an output result SHALL be consumed only in a cycle where out_valid and out_ready are both 1.
REQ-014 The FSM SHALL have three states:
- IDLE: in_ready=1, out_valid=0.
- ACC: in_ready=1, out_valid=0.
- HOLD: in_ready=0, out_valid=1.
REQ-015 In IDLE, an accepted word SHALL load acc with in_data and set cnt to 1, then go to ACC; if FRAME_LEN==1 it SHALL go directly to HOLD instead.
REQ-016 In ACC, an accepted word SHALL update acc to acc XOR in_data and increment cnt; the accept that brings cnt to FRAME_LEN SHALL move the FSM to HOLD.
REQ-017 In IDLE and ACC, cycles with in_valid=0 SHALL leave acc, cnt and the state unchanged.
REQ-018 out_valid SHALL rise in the cycle after the last word of the frame is accepted (latency 1).
REQ-019 While in HOLD:
- out_xor SHALL equal acc, out_parity SHALL equal the reduction XOR of acc, and out_count SHALL equal cnt.
- All outputs SHALL stay stable until the result is consumed.
REQ-020 When the result is consumed, the block SHALL clear acc and cnt to 0 and return to IDLE; in_ready SHALL be 1 in the next cycle.
- There is no same-cycle bypass, so minimum frame period is FRAME_LEN+1 cycles.
REQ-021 Outside HOLD, out_xor, out_parity and out_count SHALL be 0.
REQ-022 cnt SHALL never exceed FRAME_LEN; no wrap-around is permitted.

Reset
REQ-023 When rst_n=0 at a rising edge of clk, the block SHALL go to IDLE with acc=0 and cnt=0; in_ready SHALL be 1 and out_valid, out_xor, out_parity and out_count SHALL be 0 in the following cycle.
REQ-024 Reset SHALL take priority over any handshake in the same cycle.
REQ-025 A reset in the middle of a frame or during HOLD SHALL discard the partial frame or pending result with no output.

Configuration
REQ-026 When macro XOR_ACC_EARLY_LAST_EN is defined, the block SHALL add input port in_last (1 bit).
- An accepted word with in_last=1 SHALL end the frame: the FSM goes to HOLD with out_count equal to the words received so far (1 to FRAME_LEN).
- in_last on the FRAME_LEN-th word SHALL behave the same as without it.
REQ-027 When XOR_ACC_EARLY_LAST_EN is undefined, the port SHALL be absent and a frame SHALL always be exactly FRAME_LEN words.

Structure
REQ-028 Shared package xor_acc_pkg SHALL hold:
- the FSM state typedef (IDLE, ACC, HOLD);
- default constants XOR_ACC_WIDTH_DEF=8 and XOR_ACC_FRAME_LEN_DEF=4.
REQ-029 The XOR-reduction for out_parity SHALL be a sub-module named xor_reduce, parameterised by WIDTH and purely combinational; all other logic SHALL be flat in xor_acc_stream.

Verification
REQ-030 Basic frame: WIDTH=8, FRAME_LEN=4, words 0x01, 0x02, 0x04, 0x08 back-to-back with out_ready=1 -> out_valid rises 1 cycle after 0x08 is accepted, out_xor=0x0F, out_parity=0, out_count=4.
REQ-031 Backpressure: words 0xFF, 0x00, 0x00, 0x01 with out_ready=0 for 5 cycles -> out_xor=0xFE and out_parity=1 held stable, in_ready=0 throughout; after out_ready=1, IDLE and in_ready=1 the next cycle.
REQ-032 Gaps: words 0xAA, 0x55, 0xAA, 0x55 with in_valid=0 cycles between them -> out_xor=0x00, out_count=4, no early out_valid.
REQ-033 Reset mid-frame: rst_n=0 after 2 of 4 words, then a full new frame 0x10, 0x20, 0x40, 0x80 -> out_xor=0xF0, with no contribution from pre-reset words.
REQ-034 FRAME_LEN=1: word 0x3C -> out_valid on the next cycle with out_xor=0x3C, out_parity=0, out_count=1.
REQ-035 With XOR_ACC_EARLY_LAST_EN defined: words 0x0F then 0xF1 with in_last=1 -> out_xor=0xFE, out_count=2, out_parity=1.
